// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, waits a fixed memory access time,
// then hands one instruction at a time to decode with a valid/stall handshake.
module imem_fetch_ctrl #(
    parameter int unsigned RD_WAIT   = 2,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [63:0] MEM_BYTES = 64'd160
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    output logic [63:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [63:0] PC,
    output logic        InstrValid,
    output logic        Halted,
    output logic        Fault
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [63:0] pc_reg;
    logic [31:0] instr_reg;
    logic        valid_reg;
    logic        halted_reg;
    logic        fault_reg;
    logic        pc_bad;

    assign pc_bad = (pc_reg[1:0] != 2'b00) || (pc_reg >= MEM_BYTES);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg  <= S_REQ;
            cnt_reg    <= 4'd0;
            pc_reg     <= RESET_PC;
            instr_reg  <= 32'h0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    // A redirect replaces the address before it is range-checked.
                    if (Redirect) begin
                        pc_reg <= RedirectPC;
                    end else if (pc_bad) begin
                        fault_reg <= 1'b1;
                        state_reg <= S_FAULT;
                    end else begin
                        cnt_reg   <= WAIT_LOAD;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (Redirect) begin
                        pc_reg    <= RedirectPC;
                        cnt_reg   <= 4'd0;
                        state_reg <= S_REQ;
                    end else if (cnt_reg == 4'd0) begin
                        instr_reg <= IMemData;
                        if (IMemData == 32'h0) begin
                            halted_reg <= 1'b1;
                            state_reg  <= S_HALT;
                        end else begin
                            valid_reg <= 1'b1;
                            state_reg <= S_VALID;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                S_VALID: begin
                    // Redirect takes precedence over both Stall and the sequential step.
                    if (Redirect) begin
                        pc_reg    <= RedirectPC;
                        valid_reg <= 1'b0;
                        state_reg <= S_REQ;
                    end else if (!Stall) begin
                        pc_reg    <= pc_reg + 64'd4;
                        valid_reg <= 1'b0;
                        state_reg <= S_REQ;
                    end
                end
                S_HALT, S_FAULT: begin
                    state_reg <= state_reg;
                end
                default: begin
                    state_reg <= S_REQ;
                end
            endcase
        end
    end

    assign IMemAddr   = pc_reg;
    assign PC         = pc_reg;
    assign Instr      = instr_reg;
    assign InstrValid = valid_reg;
    assign Halted     = halted_reg;
    assign Fault      = fault_reg;

endmodule
